// File: rtl/reqrsp_req_slice.sv
// reqrsp_req_slice
// Buffered request slice with an outstanding-transaction limiter, placed
// directly upstream of the reqrsp-to-AXI converter.
//
// Optional feature macro: REQRSP_REQ_SLICE_RSP_CUT_EN
//   defined   : one-entry response register between mst_rsp_i.p and slv_rsp_o.p
//   undefined : combinational response path
//
// Ports:
//   clk_i          clock (single domain)
//   rst_i          synchronous active-high reset
//   slv_req_i      request from the core side (q, q_valid, p_ready)
//   slv_rsp_o      response to the core side (p, p_valid, q_ready)
//   mst_req_o      request to the reqrsp-to-AXI converter
//   mst_rsp_i      response from the converter
//   idle_o         nothing buffered, nothing outstanding, response register empty
//   outstanding_o  requests accepted but not yet answered upstream

package reqrsp_req_slice_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } q_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } p_chan_t;

    typedef struct packed {
        q_chan_t q;
        logic    q_valid;
        logic    p_ready;
    } req_t;

    typedef struct packed {
        p_chan_t p;
        logic    p_valid;
        logic    q_ready;
    } rsp_t;

endpackage

module reqrsp_req_slice #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned Depth          = 2,
    parameter int unsigned MaxOutstanding = 8,
    parameter type reqrsp_req_t = reqrsp_req_slice_pkg::req_t,
    parameter type reqrsp_rsp_t = reqrsp_req_slice_pkg::rsp_t,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  reqrsp_req_t     slv_req_i,
    output reqrsp_rsp_t     slv_rsp_o,
    output reqrsp_req_t     mst_req_o,
    input  reqrsp_rsp_t     mst_rsp_i,
    output logic            idle_o,
    output logic [CntW-1:0] outstanding_o
);

    // Payload widths: the request/response structs carry exactly two
    // single-bit handshake fields besides the payload.
    localparam int unsigned QW   = $bits(reqrsp_req_t) - 2;
    localparam int unsigned PW   = $bits(reqrsp_rsp_t) - 2;
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = $clog2(Depth + 1);

    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);
    localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
        $error("reqrsp_req_slice: DataWidth must be 32 or 64");
    end
    if (Depth < 1) begin : g_bad_depth
        $error("reqrsp_req_slice: Depth must be at least 1");
    end
    if (MaxOutstanding < 1) begin : g_bad_max_outstanding
        $error("reqrsp_req_slice: MaxOutstanding must be at least 1");
    end

    logic [QW-1:0]   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0] occ_q;
    logic [CntW-1:0] cnt_q;

    logic fifo_full, fifo_empty;
    logic q_ready, push, pop, rsp_hs;
    logic rsp_reg_empty, mst_p_ready, slv_p_valid;
    logic [PW-1:0] slv_p;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (occ_q == DepthOcc);
    assign fifo_empty = (occ_q == '0);

    // Only local state feeds q_ready, so a pop in a full cycle cannot make
    // room for a push in that same cycle.
    assign q_ready = !fifo_full && (cnt_q < MaxCnt);
    assign push    = slv_req_i.q_valid && q_ready;
    assign pop     = !fifo_empty && mst_rsp_i.q_ready;
    assign rsp_hs  = slv_p_valid && slv_req_i.p_ready;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= slv_req_i.q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (!push && pop) begin
                occ_q <= occ_q - 1'b1;
            end
            if (push && !rsp_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push && rsp_hs) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef REQRSP_REQ_SLICE_RSP_CUT_EN
    logic [PW-1:0] rsp_q;
    logic          rsp_valid_q;

    assign rsp_reg_empty = !rsp_valid_q;
    assign mst_p_ready   = rsp_reg_empty || slv_req_i.p_ready;
    assign slv_p_valid   = rsp_valid_q;
    assign slv_p         = rsp_q;

    // A load wins over a drain so load-and-drain in one cycle keeps the
    // register full with the new response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
        end else if (mst_rsp_i.p_valid && mst_p_ready) begin
            rsp_valid_q <= 1'b1;
        end else if (slv_req_i.p_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mst_rsp_i.p_valid && mst_p_ready) begin
            rsp_q <= mst_rsp_i.p;
        end
    end
`else
    assign rsp_reg_empty = 1'b1;
    assign mst_p_ready   = slv_req_i.p_ready;
    assign slv_p_valid   = mst_rsp_i.p_valid;
    assign slv_p         = mst_rsp_i.p;
`endif

    always_comb begin
        slv_rsp_o         = '0;
        slv_rsp_o.q_ready = q_ready;
        slv_rsp_o.p_valid = slv_p_valid;
        slv_rsp_o.p       = slv_p;

        mst_req_o         = '0;
        mst_req_o.q_valid = !fifo_empty;
        mst_req_o.q       = mem_q[rd_ptr_q];
        mst_req_o.p_ready = mst_p_ready;
    end

    assign idle_o        = fifo_empty && (cnt_q == '0) && rsp_reg_empty;
    assign outstanding_o = cnt_q;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_hs |-> (cnt_q != '0));

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.q_valid && !q_ready) |=> (slv_req_i.q_valid && $stable(slv_req_i.q)));

endmodule

// File: tb/tb_reqrsp_req_slice.sv
module tb_reqrsp_req_slice;
    import reqrsp_req_slice_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    req_t       slv_req, mst_req;
    rsp_t       slv_rsp, mst_rsp;
    logic       idle;
    logic [2:0] outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reqrsp_req_slice #(
        .DataWidth      (32),
        .Depth          (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slv_req_i     (slv_req),
        .slv_rsp_o     (slv_rsp),
        .mst_req_o     (mst_req),
        .mst_rsp_i     (mst_rsp),
        .idle_o        (idle),
        .outstanding_o (outstanding)
    );

    typedef struct {
        logic        qv;
        logic [31:0] addr;
        logic        mqr;
        logic        mpv;
        logic [31:0] pdata;
        logic        spr;
        logic        e_qready;
        logic        e_mqv;
        logic [31:0] e_maddr;
        logic        e_spv;
        logic [2:0]  e_out;
        logic        e_idle;
        logic        e_mpr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic qv, input logic [31:0] addr, input logic mqr,
                                input logic mpv, input logic [31:0] pdata, input logic spr,
                                input logic e_qready, input logic e_mqv, input logic [31:0] e_maddr,
                                input logic e_spv, input logic [2:0] e_out, input logic e_idle,
                                input logic e_mpr);
        vec_t v;
        v.qv = qv; v.addr = addr; v.mqr = mqr; v.mpv = mpv; v.pdata = pdata; v.spr = spr;
        v.e_qready = e_qready; v.e_mqv = e_mqv; v.e_maddr = e_maddr; v.e_spv = e_spv;
        v.e_out = e_out; v.e_idle = e_idle; v.e_mpr = e_mpr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_q(input logic v, input logic [31:0] addr, input logic wr,
                         input logic [31:0] data, input logic [3:0] strb);
        slv_req.q_valid = v;
        slv_req.q.addr  = addr;
        slv_req.q.write = wr;
        slv_req.q.amo   = 4'h0;
        slv_req.q.data  = data;
        slv_req.q.strb  = strb;
        slv_req.q.size  = 2'd2;
    endtask

    task automatic set_rsp(input logic mqr, input logic mpv, input logic [31:0] pdata,
                           input logic spr);
        mst_rsp.q_ready = mqr;
        mst_rsp.p_valid = mpv;
        mst_rsp.p.data  = pdata;
        mst_rsp.p.error = 1'b0;
        slv_req.p_ready = spr;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (!idle && c < 8) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk(name, 128'(idle), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        q_chan_t hs_q[$];
        int      hs_cyc[$];
        q_chan_t e;
        int      cyc, k, c;
        logic    acc;

        // ---------------- reset values ----------------
        rst = 1'b1;
        slv_req = '0;
        mst_rsp = '0;
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_rsp(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst mst q_valid",   128'(mst_req.q_valid), 128'(0));
        chk("rst slv p_valid",   128'(slv_rsp.p_valid), 128'(0));
        chk("rst slv q_ready",   128'(slv_rsp.q_ready), 128'(1));
        chk("rst idle",          128'(idle),            128'(1));
        chk("rst outstanding",   128'(outstanding),     128'(0));
        chk("rst mst p_ready hi", 128'(mst_req.p_ready), 128'(1));
        slv_req.p_ready = 1'b0;
        #1;
`ifdef REQRSP_REQ_SLICE_RSP_CUT_EN
        chk("rst mst p_ready lo", 128'(mst_req.p_ready), 128'(1));
`else
        chk("rst mst p_ready lo", 128'(mst_req.p_ready), 128'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        slv_req.p_ready = 1'b1;

`ifndef REQRSP_REQ_SLICE_RSP_CUT_EN
        // ---------------- cycle table: single read, FIFO full, response drain ----------------
        //           qv  addr          mqr  mpv  pdata         spr | qrdy mqv maddr       spv out idle mpr
        tv.push_back(mk(1, 32'h1000, 0, 0, 32'h0,        1,   1, 0, 32'h0,    0, 0, 1, 1));
        tv.push_back(mk(0, 32'h0,    1, 0, 32'h0,        1,   1, 1, 32'h1000, 0, 1, 0, 1));
        tv.push_back(mk(0, 32'h0,    1, 1, 32'hDEADBEEF, 1,   1, 0, 32'h0,    1, 1, 0, 1));
        tv.push_back(mk(0, 32'h0,    0, 0, 32'h0,        1,   1, 0, 32'h0,    0, 0, 1, 1));
        tv.push_back(mk(1, 32'h2000, 0, 0, 32'h0,        1,   1, 0, 32'h0,    0, 0, 1, 1));
        tv.push_back(mk(1, 32'h2004, 0, 0, 32'h0,        1,   1, 1, 32'h2000, 0, 1, 0, 1));
        tv.push_back(mk(1, 32'h2008, 0, 0, 32'h0,        1,   0, 1, 32'h2000, 0, 2, 0, 1));
        tv.push_back(mk(1, 32'h2008, 1, 0, 32'h0,        1,   0, 1, 32'h2000, 0, 2, 0, 1));
        tv.push_back(mk(1, 32'h2008, 0, 0, 32'h0,        0,   1, 1, 32'h2004, 0, 2, 0, 0));
        tv.push_back(mk(0, 32'h0,    1, 0, 32'h0,        1,   0, 1, 32'h2004, 0, 3, 0, 1));
        tv.push_back(mk(0, 32'h0,    1, 0, 32'h0,        1,   1, 1, 32'h2008, 0, 3, 0, 1));
        tv.push_back(mk(0, 32'h0,    0, 1, 32'h11111111, 0,   1, 0, 32'h0,    1, 3, 0, 0));
        tv.push_back(mk(0, 32'h0,    0, 1, 32'h11111111, 1,   1, 0, 32'h0,    1, 3, 0, 1));
        tv.push_back(mk(0, 32'h0,    0, 1, 32'h22222222, 1,   1, 0, 32'h0,    1, 2, 0, 1));
        tv.push_back(mk(0, 32'h0,    0, 1, 32'h33333333, 1,   1, 0, 32'h0,    1, 1, 0, 1));
        tv.push_back(mk(0, 32'h0,    0, 0, 32'h0,        1,   1, 0, 32'h0,    0, 0, 1, 1));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            set_q(tv[i].qv, tv[i].addr, 1'b0, 32'h0, 4'hF);
            set_rsp(tv[i].mqr, tv[i].mpv, tv[i].pdata, tv[i].spr);
            #1;
            chk($sformatf("vec%0d q_ready", i),     128'(slv_rsp.q_ready), 128'(tv[i].e_qready));
            chk($sformatf("vec%0d mst q_valid", i), 128'(mst_req.q_valid), 128'(tv[i].e_mqv));
            if (tv[i].e_mqv)
                chk($sformatf("vec%0d mst addr", i), 128'(mst_req.q.addr), 128'(tv[i].e_maddr));
            chk($sformatf("vec%0d slv p_valid", i), 128'(slv_rsp.p_valid), 128'(tv[i].e_spv));
            if (tv[i].e_spv)
                chk($sformatf("vec%0d slv p data", i), 128'(slv_rsp.p.data), 128'(tv[i].pdata));
            chk($sformatf("vec%0d outstanding", i), 128'(outstanding),     128'(tv[i].e_out));
            chk($sformatf("vec%0d idle", i),        128'(idle),            128'(tv[i].e_idle));
            chk($sformatf("vec%0d mst p_ready", i), 128'(mst_req.p_ready), 128'(tv[i].e_mpr));
        end
`endif

        // ---------------- back-to-back 16 writes ----------------
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_rsp(1'b1, 1'b0, 32'h0, 1'b1);
        cyc = 0;
        while (hs_q.size() < 16 && cyc < 40) begin
            @(negedge clk);
            if (cyc < 16)
                set_q(1'b1, 32'h3000 + 32'(4 * cyc), 1'b1, 32'h01010101 * 32'(cyc), 4'(cyc));
            else
                set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
            // the converter answers in the same cycle it accepts
            mst_rsp.p_valid = mst_req.q_valid;
            mst_rsp.p.data  = mst_req.q.addr;
            #1;
            if (cyc < 16)
                chk($sformatf("b2b q_ready c%0d", cyc), 128'(slv_rsp.q_ready), 128'(1));
            if (mst_req.q_valid) begin
                hs_q.push_back(mst_req.q);
                hs_cyc.push_back(cyc);
            end
            cyc++;
        end
        chk("b2b handshake count", 128'(hs_q.size()), 128'(16));
        for (int i = 0; i < hs_q.size(); i++) begin
            e.addr  = 32'h3000 + 32'(4 * i);
            e.write = 1'b1;
            e.amo   = 4'h0;
            e.data  = 32'h01010101 * 32'(i);
            e.strb  = 4'(i);
            e.size  = 2'd2;
            chk($sformatf("b2b payload %0d", i), 128'(hs_q[i]),   128'(e));
            chk($sformatf("b2b cycle %0d", i),   128'(hs_cyc[i]), 128'(i + 1));
        end
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        mst_rsp.p_valid = 1'b0;
        #1;
        wait_idle("b2b idle after drain");

        // ---------------- outstanding limit ----------------
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_q(k < 6, 32'h4000 + 32'(4 * k), 1'b0, 32'h0, 4'hF);
            set_rsp(1'b1, 1'b0, 32'h0, 1'b1);
            #1;
            if (slv_req.q_valid && slv_rsp.q_ready) k++;
        end
        chk("limit accepted", 128'(k), 128'(4));
        chk("limit outstanding", 128'(outstanding), 128'(4));
        chk("limit q_ready", 128'(slv_rsp.q_ready), 128'(0));
        // one response returned while the fifth request is still offered
        @(negedge clk);
        mst_rsp.p_valid = 1'b1;
        mst_rsp.p.data  = 32'h0000AAAA;
        #1;
        chk("limit q_ready with rsp", 128'(slv_rsp.q_ready), 128'(0));
        acc = 1'b0;
        c = 0;
        while (!acc && c < 6) begin
            @(negedge clk);
            mst_rsp.p_valid = 1'b0;
            #1;
            if (slv_rsp.q_ready) acc = 1'b1;
            c++;
        end
        chk("limit reaccept", 128'(acc), 128'(1));
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        chk("limit outstanding after reaccept", 128'(outstanding), 128'(4));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mst_rsp.p_valid = 1'b1;
            mst_rsp.p.data  = 32'h0000B000 + 32'(i);
        end
        @(negedge clk);
        mst_rsp.p_valid = 1'b0;
        #1;
        wait_idle("limit idle after drain");
        chk("limit outstanding drained", 128'(outstanding), 128'(0));

`ifdef REQRSP_REQ_SLICE_RSP_CUT_EN
        // ---------------- response back-pressure through the register ----------------
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_q(1'b1, 32'h6000 + 32'(4 * i), 1'b0, 32'h0, 4'hF);
            set_rsp(1'b1, 1'b0, 32'h0, 1'b0);
        end
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        mst_rsp.p_valid = 1'b1;
        mst_rsp.p.data  = 32'hAAAA0001;
        #1;
        chk("cut p_ready empty", 128'(mst_req.p_ready), 128'(1));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mst_rsp.p.data = 32'hAAAA0002;
            #1;
            chk($sformatf("cut held p_ready %0d", i), 128'(mst_req.p_ready), 128'(0));
            chk($sformatf("cut held valid %0d", i),   128'(slv_rsp.p_valid), 128'(1));
            chk($sformatf("cut held data %0d", i),    128'(slv_rsp.p.data),  128'(32'hAAAA0001));
        end
        @(negedge clk);
        slv_req.p_ready = 1'b1;
        #1;
        chk("cut release first", 128'(slv_rsp.p.data), 128'(32'hAAAA0001));
        chk("cut release p_ready", 128'(mst_req.p_ready), 128'(1));
        @(negedge clk);
        mst_rsp.p_valid = 1'b0;
        #1;
        chk("cut second valid", 128'(slv_rsp.p_valid), 128'(1));
        chk("cut second data",  128'(slv_rsp.p.data),  128'(32'hAAAA0002));
        @(negedge clk);
        #1;
        chk("cut drained valid", 128'(slv_rsp.p_valid), 128'(0));
        chk("cut drained idle",  128'(idle),            128'(1));
`endif

        // ---------------- mid-operation reset ----------------
        @(negedge clk);
        set_q(1'b1, 32'h5000, 1'b0, 32'h0, 4'hF);
        set_rsp(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        set_q(1'b1, 32'h5004, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        mst_rsp.q_ready = 1'b1;
        @(negedge clk);
        set_q(1'b1, 32'h5008, 1'b0, 32'h0, 4'hF);
        mst_rsp.q_ready = 1'b0;
        @(negedge clk);
        set_q(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #1;
        chk("mid pre q_ready full", 128'(slv_rsp.q_ready), 128'(0));
        chk("mid pre outstanding",  128'(outstanding),     128'(3));
        chk("mid pre head",         128'(mst_req.q.addr),  128'(32'h5004));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rst mst q_valid",  128'(mst_req.q_valid), 128'(0));
        chk("mid rst outstanding",  128'(outstanding),     128'(0));
        chk("mid rst idle",         128'(idle),            128'(1));
        chk("mid rst q_ready",      128'(slv_rsp.q_ready), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
